// File: rtl/labkit_pkg.sv
// Shared types and constants for the labkit front-panel input path.
// Event indices double as the priority order: a lower index wins.
package labkit_pkg;

    typedef enum logic {
        EDIT    = 1'b0,
        PENDING = 1'b1
    } state_t;

    typedef enum logic [2:0] {
        ACT_NONE,
        ACT_CLEAR,
        ACT_COMMIT,
        ACT_WRITE,
        ACT_LEFT,
        ACT_RIGHT
    } action_t;

    localparam int NIBBLE_W          = 4;
    localparam int BLINK_DIV_DEFAULT = 12_500_000;

    localparam int NUM_BTNS  = 5;
    localparam int EV_CLEAR  = 0;
    localparam int EV_COMMIT = 1;
    localparam int EV_WRITE  = 2;
    localparam int EV_LEFT   = 3;
    localparam int EV_RIGHT  = 4;

endpackage

// File: rtl/btn_edge.sv
// Rising-edge detector for one debounced button level.
// The input register plus one history flop give the one-cycle press-to-event latency.
module btn_edge (
    input  logic clock,
    input  logic reset_n,
    input  logic level,
    output logic pulse
);

    logic level_q;
    logic prev_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            level_q <= level;
            prev_q  <= level_q;
        end
    end

    assign pulse = level_q & ~prev_q;

endmodule

// File: rtl/hex_entry.sv
// Front-panel hex word editor: builds a word digit by digit, blinks the cursor digit,
// and hands committed words to the processor over a valid/ready handshake.
module hex_entry
    import labkit_pkg::*;
#(
    parameter int DIGITS    = 8,
    parameter int BLINK_DIV = BLINK_DIV_DEFAULT
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic [NIBBLE_W-1:0]          digit_in,
    input  logic                         btn_left,
    input  logic                         btn_right,
    input  logic                         btn_write,
    input  logic                         btn_commit,
    input  logic                         btn_clear,
    output logic [NIBBLE_W*DIGITS-1:0]   edit_word,
    output logic [$clog2(DIGITS)-1:0]    cursor,
    output logic [DIGITS-1:0]            blank_mask,
    output logic [NIBBLE_W*DIGITS-1:0]   out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output state_t                       state
);

    // Handshake: a word transfers on the first edge where out_valid and out_ready are
    // both high; out_data is frozen while out_valid is high, and out_ready may lead.

    localparam int CUR_W = $clog2(DIGITS);
    localparam int BW    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CUR_W-1:0] CUR_LAST   = CUR_W'(DIGITS - 1);
    localparam logic [BW-1:0]    BLINK_LAST = BW'(BLINK_DIV - 1);

    logic [NUM_BTNS-1:0] levels;
    logic [NUM_BTNS-1:0] ev;
    logic [NIBBLE_W-1:0] digit_q;
    logic [BW-1:0]       blink_cnt;
    logic                phase;
    action_t             act;

    always_comb begin
        levels            = '0;
        levels[EV_CLEAR]  = btn_clear;
        levels[EV_COMMIT] = btn_commit;
        levels[EV_WRITE]  = btn_write;
        levels[EV_LEFT]   = btn_left;
        levels[EV_RIGHT]  = btn_right;
    end

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_btn
        btn_edge u_edge (
            .clock   (clock),
            .reset_n (reset_n),
            .level   (levels[i]),
            .pulse   (ev[i])
        );
    end

    // One action per cycle; a commit while a word is pending is treated as absent.
    always_comb begin
        act = ACT_NONE;
        if (ev[EV_CLEAR])                         act = ACT_CLEAR;
        else if (ev[EV_COMMIT] && state == EDIT)  act = ACT_COMMIT;
        else if (ev[EV_WRITE])                    act = ACT_WRITE;
        else if (ev[EV_LEFT])                     act = ACT_LEFT;
        else if (ev[EV_RIGHT])                    act = ACT_RIGHT;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= EDIT;
            edit_word <= '0;
            cursor    <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            digit_q   <= '0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            // digit_q lines up with the event, so a held button writes the press-time digit.
            digit_q <= digit_in;

            case (act)
                ACT_CLEAR: begin
                    edit_word <= '0;
                    cursor    <= '0;
                end
                ACT_COMMIT: begin
                    out_data  <= edit_word;
                    out_valid <= 1'b1;
                    state     <= PENDING;
                end
                ACT_WRITE: edit_word[NIBBLE_W*int'(cursor) +: NIBBLE_W] <= digit_q;
                ACT_LEFT:  cursor <= (cursor == CUR_LAST) ? '0 : cursor + 1'b1;
                ACT_RIGHT: cursor <= (cursor == '0) ? CUR_LAST : cursor - 1'b1;
                default: ;
            endcase

            if (state == PENDING && out_ready) begin
                out_valid <= 1'b0;
                state     <= EDIT;
            end

            // Any visible edit restarts the blink in the shown phase.
            if (act inside {ACT_CLEAR, ACT_WRITE, ACT_LEFT, ACT_RIGHT}) begin
                blink_cnt <= '0;
                phase     <= 1'b0;
            end else if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        blank_mask = '0;
        if (phase) blank_mask[cursor] = 1'b1;
    end

endmodule
